// File: rtl/spi_pkg.sv
// Shared encodings and defaults for the configurable SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } spi_state_t;

  // SPI modes as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int DEFAULT_DATA_W  = 8;
  localparam int DEFAULT_CLK_DIV = 3;

  function automatic logic mode_cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic logic mode_cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timer: tick is high combinationally in the last cycle of each CLK_DIV-cycle window.
// No backpressure; clear restarts the window, enable low freezes the count.
module spi_tick_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master_cfg.sv
// Full-duplex SPI master; rx_valid pulses CLK_DIV*(2*DATA_W+2) cycles after start is taken.
// start is only accepted in IDLE (never queued); optional LSB-first mode under SPI_MASTER_LSB_FIRST_EN.
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DATA_W-1:0] data_tx,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  input  logic              miso,
  output logic              mosi,
  output logic              sck,
  output logic              ss_n,
  output logic              busy,
  output logic [DATA_W-1:0] data_rx,
  output logic              rx_valid
);

  localparam int EW = $clog2(2 * DATA_W);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  spi_state_t        state, state_nxt;
  logic [DATA_W-1:0] tx_sh, tx_nxt;
  logic [DATA_W-1:0] rx_sh, rx_nxt;
  logic [EW-1:0]     edge_cnt, edge_nxt;
  logic              cpol_l, cpol_nxt;
  logic              cpha_l, cpha_nxt;
  logic              lsb_l, lsb_nxt;
  logic              lsb_in;
  logic              mosi_r, mosi_nxt;
  logic              sck_r, sck_nxt;
  logic              ss_n_r, ss_n_nxt;
  logic              busy_r, busy_nxt;
  logic              rxv_r, rxv_nxt;
  logic [DATA_W-1:0] drx_r, drx_nxt;
  logic              tick, tick_clear, tick_en;
  logic              leading, sample;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  assign tick_en    = (state == SETUP) || (state == SHIFT) || (state == HOLD);
  assign tick_clear = (state_nxt != state);

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (tick_clear),
    .enable (tick_en),
    .tick   (tick)
  );

  // Even edge index is the first toggle of a bit; cpha picks which of the pair samples.
  assign leading = ~edge_cnt[0];
  assign sample  = leading ^ cpha_l;

  always_comb begin
    state_nxt = state;
    tx_nxt    = tx_sh;
    rx_nxt    = rx_sh;
    edge_nxt  = edge_cnt;
    cpol_nxt  = cpol_l;
    cpha_nxt  = cpha_l;
    lsb_nxt   = lsb_l;
    mosi_nxt  = mosi_r;
    sck_nxt   = sck_r;
    ss_n_nxt  = ss_n_r;
    busy_nxt  = busy_r;
    rxv_nxt   = 1'b0;
    drx_nxt   = drx_r;

    case (state)
      IDLE: begin
        ss_n_nxt = 1'b1;
        sck_nxt  = cpol;
        busy_nxt = 1'b0;
        if (start) begin
          state_nxt = SETUP;
          cpol_nxt  = cpol;
          cpha_nxt  = cpha;
          lsb_nxt   = lsb_in;
          busy_nxt  = 1'b1;
          ss_n_nxt  = 1'b0;
          edge_nxt  = '0;
          rx_nxt    = '0;
          tx_nxt    = data_tx;
          if (!cpha) begin
            mosi_nxt = lsb_in ? data_tx[0] : data_tx[DATA_W-1];
            tx_nxt   = lsb_in ? (data_tx >> 1) : (data_tx << 1);
          end
        end
      end

      SETUP: begin
        if (tick) state_nxt = SHIFT;
      end

      SHIFT: begin
        if (tick) begin
          sck_nxt  = ~sck_r;
          edge_nxt = edge_cnt + EW'(1);
          if (sample) begin
            rx_nxt = lsb_l ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
          end else if (edge_cnt != LAST_EDGE) begin
            mosi_nxt = lsb_l ? tx_sh[0] : tx_sh[DATA_W-1];
            tx_nxt   = lsb_l ? (tx_sh >> 1) : (tx_sh << 1);
          end
          if (edge_cnt == LAST_EDGE) state_nxt = HOLD;
        end
      end

      HOLD: begin
        if (tick) begin
          state_nxt = DONE;
          rxv_nxt   = 1'b1;
          drx_nxt   = rx_sh;
          ss_n_nxt  = 1'b1;
          mosi_nxt  = 1'b0;
        end
      end

      DONE: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tx_sh    <= '0;
      rx_sh    <= '0;
      edge_cnt <= '0;
      cpol_l   <= 1'b0;
      cpha_l   <= 1'b0;
      lsb_l    <= 1'b0;
      mosi_r   <= 1'b0;
      sck_r    <= 1'b0;
      ss_n_r   <= 1'b1;
      busy_r   <= 1'b0;
      rxv_r    <= 1'b0;
      drx_r    <= '0;
    end else begin
      state    <= state_nxt;
      tx_sh    <= tx_nxt;
      rx_sh    <= rx_nxt;
      edge_cnt <= edge_nxt;
      cpol_l   <= cpol_nxt;
      cpha_l   <= cpha_nxt;
      lsb_l    <= lsb_nxt;
      mosi_r   <= mosi_nxt;
      sck_r    <= sck_nxt;
      ss_n_r   <= ss_n_nxt;
      busy_r   <= busy_nxt;
      rxv_r    <= rxv_nxt;
      drx_r    <= drx_nxt;
    end
  end

  assign mosi     = mosi_r;
  assign sck      = sck_r;
  assign ss_n     = ss_n_r;
  assign busy     = busy_r;
  assign rx_valid = rxv_r;
  assign data_rx  = drx_r;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg: an 8-bit/div-3 instance driven through all modes against a slave model,
// and a 16-bit/div-1 instance run back-to-back in loopback with start held high.
module tb_spi_master_cfg;
  import spi_pkg::*;

  localparam int WA = 8;
  localparam int DA = 3;
  localparam int WB = 16;
  localparam int DB = 1;
  localparam int LAT_A = DA * (2 * WA + 2);
  localparam int LAT_B = DB * (2 * WB + 2);
  localparam int PER_B = LAT_B + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [WA-1:0] rev_a(input logic [WA-1:0] v);
    logic [WA-1:0] r;
    for (int i = 0; i < WA; i++) r[i] = v[WA-1-i];
    return r;
  endfunction

  // ---------------- DUT A: 8-bit, CLK_DIV=3 ----------------
  logic          rst_a, start_a, cpol_a, cpha_a, miso_a, mosi_a, sck_a, ss_n_a, busy_a, rxv_a;
  logic [WA-1:0] dtx_a, drx_a;
  logic          loop_a, slv_miso_a;
`ifdef SPI_MASTER_LSB_FIRST_EN
  logic          lsb_a;
`endif

  assign miso_a = loop_a ? mosi_a : slv_miso_a;

  spi_master_cfg #(.DATA_W(WA), .CLK_DIV(DA)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .cpol(cpol_a), .cpha(cpha_a), .data_tx(dtx_a),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first(lsb_a),
`endif
    .miso(miso_a), .mosi(mosi_a), .sck(sck_a), .ss_n(ss_n_a), .busy(busy_a),
    .data_rx(drx_a), .rx_valid(rxv_a)
  );

  // ---------------- DUT B: 16-bit, CLK_DIV=1, loopback ----------------
  logic          rst_b, start_b, mosi_b, sck_b, ss_n_b, busy_b, rxv_b;
  logic [WB-1:0] dtx_b, drx_b;

  spi_master_cfg #(.DATA_W(WB), .CLK_DIV(DB)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .cpol(1'b0), .cpha(1'b0), .data_tx(dtx_b),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first(1'b0),
`endif
    .miso(mosi_b), .mosi(mosi_b), .sck(sck_b), .ss_n(ss_n_b), .busy(busy_b),
    .data_rx(drx_b), .rx_valid(rxv_b)
  );

  // ---------------- Slave model for A ----------------
  // Sends slv_word_a, captures mosi in arrival order; results published when ss_n rises.
  logic [WA-1:0] slv_word_a;
  logic          slv_cpha_a, slv_lsb_a;
  logic [WA-1:0] cap_fin_a;
  int            rise_fin_a;

  initial begin
    logic [WA-1:0] seq, cap;
    int            nb, k, rises;
    logic          lead;
    slv_miso_a = 1'b0;
    cap_fin_a  = '0;
    rise_fin_a = 0;
    forever begin
      @(negedge ss_n_a);
      seq   = slv_lsb_a ? rev_a(slv_word_a) : slv_word_a;
      cap   = '0;
      nb    = 0;
      k     = 0;
      rises = 0;
      if (!slv_cpha_a) begin
        slv_miso_a = seq[WA-1];
        nb = 1;
      end
      while (!ss_n_a) begin
        @(sck_a or ss_n_a);
        if (!ss_n_a) begin
          if (sck_a) rises++;
          if (k < 2 * WA) begin
            lead = (k % 2 == 0);
            if (lead != slv_cpha_a) cap = {cap[WA-2:0], mosi_a};
            else if (nb < WA) begin
              slv_miso_a = seq[WA-1-nb];
              nb++;
            end
          end
          k++;
        end
      end
      cap_fin_a  = cap;
      rise_fin_a = rises;
    end
  end

  // ---------------- Scoreboards ----------------
  typedef struct {
    int            cyc;
    logic [WA-1:0] rx;
    logic [WA-1:0] cap;
    logic          cpol;
  } exp_a_t;

  typedef struct {
    int            cyc;
    logic [WB-1:0] rx;
  } exp_b_t;

  exp_a_t qa[$];
  exp_b_t qb[$];

  logic prev_rxv_a = 1'b0;
  logic prev_rxv_b = 1'b0;
  int   hi_run_b   = 0;
  logic seen_low_b = 1'b0;

  initial begin
    exp_a_t e;
    forever begin
      @(negedge clk);
      if (rxv_a) begin
        check("rxv_a_one_cycle", prev_rxv_a, 0);
        if (qa.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rxv_a_unexpected: got rx_valid=1 data_rx=0x%0h, want no pulse (t=%0t)", drx_a, $time);
        end else begin
          e = qa.pop_front();
          check("latency_a", cyc, e.cyc);
          check("data_rx_a", drx_a, e.rx);
          check("mosi_word_a", cap_fin_a, e.cap);
          check("sck_rises_a", rise_fin_a, WA);
          check("sck_idle_a", sck_a, e.cpol);
          check("ss_n_done_a", ss_n_a, 1);
          check("busy_done_a", busy_a, 1);
        end
      end
      prev_rxv_a = rxv_a;
    end
  end

  initial begin
    exp_b_t e;
    forever begin
      @(negedge clk);
      if (rxv_b) begin
        check("rxv_b_one_cycle", prev_rxv_b, 0);
        if (qb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rxv_b_unexpected: got rx_valid=1 data_rx=0x%0h, want no pulse (t=%0t)", drx_b, $time);
        end else begin
          e = qb.pop_front();
          check("latency_b", cyc, e.cyc);
          check("data_rx_b", drx_b, e.rx);
        end
      end
      prev_rxv_b = rxv_b;
      if (ss_n_b) hi_run_b++;
      else begin
        if (hi_run_b > 0 && seen_low_b) check("ss_n_gap_b_ge2", hi_run_b >= 2, 1);
        hi_run_b   = 0;
        seen_low_b = 1'b1;
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic xfer_a(input logic [1:0] mode, input logic [WA-1:0] d, input logic [WA-1:0] sw,
                        input logic lb, input logic lsb, input logic disturb);
    int     t;
    exp_a_t e;
`ifndef SPI_MASTER_LSB_FIRST_EN
    lsb = 1'b0;
`endif
    @(posedge clk);
    #1;
    cpol_a     = mode_cpol(mode);
    cpha_a     = mode_cpha(mode);
    loop_a     = lb;
    slv_word_a = sw;
    slv_cpha_a = mode_cpha(mode);
    slv_lsb_a  = lsb;
`ifdef SPI_MASTER_LSB_FIRST_EN
    lsb_a      = lsb;
`endif
    @(posedge clk);
    #1;
    start_a = 1'b1;
    dtx_a   = d;
    @(posedge clk);
    #1;
    t       = cyc;
    start_a = 1'b0;
    e.cyc  = t + LAT_A;
    e.rx   = lb ? d : sw;
    e.cap  = lsb ? rev_a(d) : d;
    e.cpol = mode_cpol(mode);
    qa.push_back(e);
    if (disturb) begin
      wait_cyc(t + 10 + $urandom_range(0, 20));
      start_a = 1'b1;
      dtx_a   = WA'($urandom);
      cpol_a  = ~cpol_a;
      cpha_a  = ~cpha_a;
`ifdef SPI_MASTER_LSB_FIRST_EN
      lsb_a   = ~lsb_a;
`endif
      @(posedge clk);
      #1;
      start_a = 1'b0;
    end
    wait_cyc(t + LAT_A + 2 + $urandom_range(0, 3));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    int            t0;
    logic [WB-1:0] wb [5];
    exp_b_t        eb;

    rst_a = 1'b0; rst_b = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    cpol_a = 1'b0; cpha_a = 1'b0; dtx_a = '0; dtx_b = '0;
    loop_a = 1'b1; slv_word_a = '0; slv_cpha_a = 1'b0; slv_lsb_a = 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
    lsb_a = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss_n_a", ss_n_a, 1);
    check("rst_sck_a", sck_a, 0);
    check("rst_mosi_a", mosi_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_rxv_a", rxv_a, 0);
    check("rst_data_rx_a", drx_a, 0);
    check("rst_ss_n_b", ss_n_b, 1);
    check("rst_busy_b", busy_b, 0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // B: start held high, back-to-back loopback transfers, data_tx changed only mid-transfer
    start_b = 1'b1;
    dtx_b   = 16'hBEEF;
    @(posedge clk);
    #1;
    t0 = cyc;
    for (int k = 0; k < 5; k++) begin
      wb[k]  = (k < 3) ? 16'hBEEF : WB'($urandom);
      eb.cyc = t0 + LAT_B + k * PER_B;
      eb.rx  = wb[k];
      qb.push_back(eb);
    end
    wait_cyc(t0 + 3 * PER_B - 10);
    dtx_b = wb[3];
    wait_cyc(t0 + 4 * PER_B - 10);
    dtx_b = wb[4];
    wait_cyc(t0 + 4 * PER_B + 6);
    start_b = 1'b0;
    wait_cyc(t0 + 5 * PER_B + 4);

    // A: directed cases
    xfer_a(MODE0, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0);
    xfer_a(MODE1, 8'hC3, 8'h3C, 1'b0, 1'b0, 1'b0);
    xfer_a(MODE2, 8'hC3, 8'h3C, 1'b0, 1'b0, 1'b0);
    xfer_a(MODE3, 8'hC3, 8'h3C, 1'b0, 1'b0, 1'b0);
    xfer_a(MODE0, 8'h5A, 8'h96, 1'b0, 1'b0, 1'b1);
    xfer_a(MODE3, 8'h0F, 8'hE1, 1'b0, 1'b0, 1'b1);

    // A: reset in the middle of a transfer
    @(posedge clk);
    #1;
    cpol_a = 1'b1; cpha_a = 1'b0; loop_a = 1'b1; slv_cpha_a = 1'b0;
    @(posedge clk);
    #1;
    start_a = 1'b1;
    dtx_a   = 8'h77;
    @(posedge clk);
    #1;
    t0      = cyc;
    start_a = 1'b0;
    wait_cyc(t0 + 20);
    rst_a = 1'b0;
    #1;
    check("abort_ss_n_a", ss_n_a, 1);
    check("abort_sck_a", sck_a, 0);
    check("abort_busy_a", busy_a, 0);
    check("abort_rxv_a", rxv_a, 0);
    check("abort_data_rx_a", drx_a, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b1;
    xfer_a(MODE2, 8'h81, 8'h7E, 1'b0, 1'b0, 1'b0);

`ifdef SPI_MASTER_LSB_FIRST_EN
    xfer_a(MODE0, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
    xfer_a(MODE1, 8'h01, 8'hB4, 1'b0, 1'b1, 1'b0);
`endif

    // A: randomized transfers
    for (int i = 0; i < 16; i++) begin
      xfer_a(2'($urandom_range(0, 3)), WA'($urandom), WA'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    t0 = cyc;
    while ((qa.size() != 0 || qb.size() != 0) && cyc < t0 + 200) begin
      @(posedge clk);
      #1;
    end
    repeat (4) @(posedge clk);
    #1;
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    check("idle_busy_a", busy_a, 0);
    check("idle_busy_b", busy_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
